dcache_refill_ctrl: RTL

Miss/write-through controller between the direct-mapped data cache in the MEM stage and backing data memory. On a load miss it stalls the pipeline, fetches the word from memory over a req/ack handshake, and writes it into the cache line. Every store is written through to memory and allocated into the cache. It also keeps hit, miss and store counters. Lines hold one 32-bit word, so a fill always overwrites the whole line.

---
 rtl/dcache_refill_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/dcache_refill_ctrl.sv
// Purpose: load-miss refill and store write-through controller between the MEM-stage data cache and backing memory.
// Latency: load hit 0 stall cycles; miss/store stall from detection until ack, then one FILL cycle (2-cycle minimum penalty).
// Backpressure: mem_req is held until mem_ack (optional TIMEOUT -> ERR); the pipeline is frozen through stall while waiting.
module dcache_refill_ctrl #(
    parameter int TIMEOUT   = 256,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [31:0]          cpu_addr,
    input  logic [31:0]          cpu_wdata,
    input  logic                 cache_hit,
    output logic                 stall,
    output logic                 fill_en,
    output logic [31:0]          fill_addr,
    output logic [31:0]          fill_data,
    output logic                 resp_valid,
    output logic [31:0]          resp_data,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic                 mem_ack,
    input  logic [31:0]          mem_rdata,
    output logic                 err,
    output logic [CNT_WIDTH-1:0] hit_cnt,
    output logic [CNT_WIDTH-1:0] miss_cnt,
    output logic [CNT_WIDTH-1:0] store_cnt
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        WR_WAIT = 3'd2,
        FILL    = 3'd3,
        ERR     = 3'd4
    } state_t;

    // Wait counter only needs to reach TIMEOUT-1.
    localparam int                   TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]        WAIT_MAX = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]        W_ONE    = TW'(1);
    localparam logic [CNT_WIDTH-1:0] C_ONE    = CNT_WIDTH'(1);

    state_t          state;
    state_t          state_nxt;
    logic [31:0]     addr_q;
    logic [31:0]     data_q;
    logic            is_load_q;
    logic [TW-1:0]   wait_cnt;
    logic            timeout_hit;

    // The TIMEOUT-th request cycle is the one where the counter sits at TIMEOUT-1.
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == WAIT_MAX);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; an ack in the timeout cycle still completes the access.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cpu_req && cpu_we) begin
                    state_nxt = WR_WAIT;
                end else if (cpu_req && !cache_hit) begin
                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (mem_ack) begin
                    state_nxt = FILL;
                end else if (timeout_hit) begin
                    state_nxt = ERR;
                end
            end
            FILL:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch request, capture read data, count wait cycles and events.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q    <= '0;
            data_q    <= '0;
            is_load_q <= 1'b0;
            wait_cnt  <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
            store_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (cpu_req && cpu_we) begin
                        addr_q    <= {cpu_addr[31:2], 2'b00};
                        data_q    <= cpu_wdata;
                        is_load_q <= 1'b0;
                        store_cnt <= store_cnt + C_ONE;
                    end else if (cpu_req && !cache_hit) begin
                        addr_q    <= {cpu_addr[31:2], 2'b00};
                        is_load_q <= 1'b1;
                        miss_cnt  <= miss_cnt + C_ONE;
                    end else if (cpu_req) begin
                        hit_cnt   <= hit_cnt + C_ONE;
                    end
                end
                RD_WAIT: begin
                    if (mem_ack) begin
                        data_q <= mem_rdata;
                    end else begin
                        wait_cnt <= wait_cnt + W_ONE;
                    end
                end
                WR_WAIT: begin
                    if (!mem_ack) begin
                        wait_cnt <= wait_cnt + W_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state and latched request; stall is held low during reset.
    always_comb begin
        stall      = 1'b0;
        fill_en    = 1'b0;
        fill_addr  = '0;
        fill_data  = '0;
        resp_valid = 1'b0;
        resp_data  = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = addr_q;
        mem_wdata  = '0;
        err        = 1'b0;
        case (state)
            IDLE: begin
                stall = cpu_req && (cpu_we || !cache_hit);
            end
            RD_WAIT: begin
                stall   = 1'b1;
                mem_req = 1'b1;
            end
            WR_WAIT: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = data_q;
            end
            FILL: begin
                fill_en    = 1'b1;
                fill_addr  = addr_q;
                fill_data  = data_q;
                resp_valid = is_load_q;
                resp_data  = is_load_q ? data_q : 32'h0;
            end
            ERR: begin
                err        = 1'b1;
                resp_valid = is_load_q;
            end
            default: ;
        endcase
        if (!rst_n) begin
            stall = 1'b0;
        end
    end

endmodule
